pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (legal range 1..256).
REQ-002 Parameter NOP_VALUE, default all-zero WIDTH-bit value, payload driven when the stage is empty or flushed.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 rdy  input  1  global ready; 0 freezes the stage.
REQ-006 flush  input  1  synchronous squash of all held entries.
REQ-007 in_valid  input  1  upstream offers in_data.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 in_ready  output  1  stage accepts a beat this cycle.
REQ-010 out_valid  output  1  out_data holds a valid beat.
REQ-011 out_data  output  WIDTH  downstream payload.
REQ-012 out_ready  input  1  downstream consumes the beat this cycle.

Function
REQ-013 Storage: main entry (main_v, main_d) and skid entry (skid_v, skid_d); states EMPTY (neither valid), ONE (main only), FULL (both valid).
REQ-014 in_ready = rdy AND NOT FULL, derived only from registered state and rdy, never from out_ready.
REQ-015 out_valid = rdy AND main_v; out_data = main_d when main_v, else NOP_VALUE.
REQ-016 Accept = in_valid AND in_ready; consume = out_valid AND out_ready.
REQ-017 EMPTY: accept -> ONE, main_d <= in_data; otherwise stay.
REQ-018 ONE: accept AND consume -> ONE, main_d <= in_data; accept only -> FULL, skid_d <= in_data; consume only -> EMPTY, main_d <= NOP_VALUE; neither -> hold.
REQ-019 FULL: consume -> ONE, main_d <= skid_d, skid_d <= NOP_VALUE; otherwise hold; no accept possible.
REQ-020 Latency: beat accepted at edge N appears on out_data after edge N when stage was EMPTY or consumed simultaneously; throughput one beat per cycle sustained.
REQ-021 Ordering: beats leave in acceptance order; no beat duplicated or dropped except by flush.
REQ-022 flush=1 (with rdy=1) at an edge: -> EMPTY, both data <= NOP_VALUE, main_v=skid_v=0; a simultaneous accept or consume is discarded (the beat is lost by design).
REQ-023 rdy=0: all registers hold, flush ignored, in_ready=0, out_valid=0; on rdy return, state resumes unchanged.

Reset
REQ-024 rst=0 asynchronously forces main_v=0, skid_v=0, main_d=skid_d=NOP_VALUE; therefore out_valid=0, out_data=NOP_VALUE, in_ready=0 during reset.
REQ-025 Reset mid-transfer discards all held beats; after deassertion the stage is EMPTY and in_ready=rdy on the first cycle.

Structure
REQ-026 Shared package holds the 2-bit stage-state encoding (EMPTY=0, ONE=1, FULL=2) and the default NOP payload constant; stage-specific payload packing (reg1, reg2, Imm, rd, rd_enable, aluop, alusel) is done by the instantiating stage, not here.
REQ-027 Single module, no sub-modules; state may be derived from main_v/skid_v rather than a separate register.

Verification
REQ-028 Reset: rst=0 with in_valid=1, in_data=0xDEADBEEF -> out_valid=0, out_data=0x0, in_ready=0; release rst, rdy=1 -> in_ready=1 next cycle.
REQ-029 Streaming: out_ready=1, beats 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on the next four cycles, in_ready stays 1.
REQ-030 Backpressure: out_ready=0, send 0xA then 0xB -> FULL, in_ready=0, out_data=0xA; raise out_ready -> 0xA then 0xB delivered, in_ready=1 after first consume.
REQ-031 Flush: FULL holding 0x11,0x22, flush=1 with in_valid=1 in_data=0x33 -> next cycle out_valid=0, out_data=NOP_VALUE, 0x33 not delivered.
REQ-032 Freeze: ONE holding 0x55, rdy=0 for 3 cycles with out_ready=1 and flush=1 -> 0x55 retained; rdy=1 -> out_valid=1, out_data=0x55.
REQ-033 Random valid/ready/flush for 10,000 cycles with WIDTH=8 and WIDTH=64 -> scoreboard ordering, no loss except flushed beats, in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: the stage-state
// encoding and the default payload driven when the stage holds nothing.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // neither entry valid
    ST_ONE   = 2'd1,  // main entry valid only
    ST_FULL  = 2'd2   // main and skid entries valid
  } stage_state_e;

  localparam int unsigned MAX_WIDTH = 256;

  // Bubble payload; the stage slices the low WIDTH bits of this.
  localparam logic [MAX_WIDTH-1:0] NOP_PAYLOAD = '0;

endpackage

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline register. in_ready comes from registered
// state and the global rdy only, so the upstream/downstream handshakes are
// decoupled combinationally. A global rdy=0 freezes everything; flush
// squashes both entries.
//
// Handshake: a beat moves across an interface on a rising edge exactly when
// its valid and ready are both 1 in the cycle before that edge. valid never
// waits for ready. in_ready does not depend on out_ready or in_valid, and
// out_valid does not depend on out_ready or in_valid.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  NOP_VALUE = NOP_PAYLOAD[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output stage_state_e     dbg_state
);

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] main_d_q, main_d_d;
  logic [WIDTH-1:0] skid_d_q, skid_d_d;
  stage_state_e     state;
  logic             accept;
  logic             consume;

  // Stage state is implied by the valid bits; skid is only ever filled
  // while main is valid.
  always_comb begin
    state = ST_EMPTY;
    if (skid_v_q)      state = ST_FULL;
    else if (main_v_q) state = ST_ONE;
  end

  assign dbg_state = state;

  // rst gating keeps in_ready low while reset is held.
  assign in_ready  = rst & rdy & ~skid_v_q;
  assign out_valid = rdy & main_v_q;
  assign out_data  = main_v_q ? main_d_q : NOP_VALUE;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  // Next-state for both entries; flush overrides any simultaneous transfer.
  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d_d = main_d_q;
    skid_d_d = skid_d_q;
    if (rdy) begin
      if (flush) begin
        main_v_d = 1'b0;
        skid_v_d = 1'b0;
        main_d_d = NOP_VALUE;
        skid_d_d = NOP_VALUE;
      end else begin
        case (state)
          ST_EMPTY: begin
            if (accept) begin
              main_v_d = 1'b1;
              main_d_d = in_data;
            end
          end
          ST_ONE: begin
            if (accept && consume) begin
              main_d_d = in_data;
            end else if (accept) begin
              skid_v_d = 1'b1;
              skid_d_d = in_data;
            end else if (consume) begin
              main_v_d = 1'b0;
              main_d_d = NOP_VALUE;
            end
          end
          ST_FULL: begin
            if (consume) begin
              main_d_d = skid_d_q;
              skid_v_d = 1'b0;
              skid_d_d = NOP_VALUE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Entry registers; reset empties the stage and restores bubble payloads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_d_q <= NOP_VALUE;
      skid_d_q <= NOP_VALUE;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_d_q <= main_d_d;
      skid_d_q <= skid_d_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a 64-bit instance for directed and random
// traffic and an 8-bit instance sharing the control inputs for random
// traffic. Each instance has a reference queue of accepted beats.
module tb_pipe_stage_skid;
  import pipe_stage_skid_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rdy, flush, in_valid, out_ready;
  logic [63:0] in_data64;
  logic [7:0]  in_data8;
  logic        in_ready64, out_valid64;
  logic [63:0] out_data64;
  logic        in_ready8, out_valid8;
  logic [7:0]  out_data8;
  stage_state_e dbg64, dbg8;

  pipe_stage_skid #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_data(in_data64), .in_ready(in_ready64),
    .out_valid(out_valid64), .out_data(out_data64), .out_ready(out_ready),
    .dbg_state(dbg64)
  );

  pipe_stage_skid #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_data(in_data8), .in_ready(in_ready8),
    .out_valid(out_valid8), .out_data(out_data8), .out_ready(out_ready),
    .dbg_state(dbg8)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q64[$];
  logic [7:0]  exp_q8[$];
  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drives one cycle of stimulus, checks both
  // instances against their queues, then advances the model over the edge.
  task automatic drive_cycle(input logic v, input logic [63:0] d, input logic ordy,
                             input logic r, input logic f);
    logic        acc64, con64, acc8, con8;
    logic        eir64, eov64, eir8, eov8;
    logic [63:0] eod64;
    logic [7:0]  eod8;
    in_valid  = v;
    in_data64 = d;
    in_data8  = d[63:56];
    out_ready = ordy;
    rdy       = r;
    flush     = f;
    #1;
    eir64 = r && (exp_q64.size() < 2);
    eov64 = r && (exp_q64.size() > 0);
    eod64 = (exp_q64.size() > 0) ? exp_q64[0] : 64'h0;
    eir8  = r && (exp_q8.size() < 2);
    eov8  = r && (exp_q8.size() > 0);
    eod8  = (exp_q8.size() > 0) ? exp_q8[0] : 8'h0;
    check_eq("in_ready64",  64'(in_ready64),  64'(eir64));
    check_eq("out_valid64", 64'(out_valid64), 64'(eov64));
    check_eq("out_data64",  out_data64,       eod64);
    check_eq("state64",     64'(dbg64),       64'(exp_q64.size()));
    check_eq("in_ready8",   64'(in_ready8),   64'(eir8));
    check_eq("out_valid8",  64'(out_valid8),  64'(eov8));
    check_eq("out_data8",   64'(out_data8),   64'(eod8));
    // in_ready must not follow out_ready combinationally.
    out_ready = ~ordy;
    #1;
    check_eq("in_ready_indep64", 64'(in_ready64), 64'(eir64));
    check_eq("in_ready_indep8",  64'(in_ready8),  64'(eir8));
    out_ready = ordy;
    #1;
    acc64 = v && eir64;
    con64 = eov64 && ordy;
    acc8  = v && eir8;
    con8  = eov8 && ordy;
    @(posedge clk);
    if (r) begin
      if (f) begin
        exp_q64.delete();
        exp_q8.delete();
      end else begin
        if (con64) void'(exp_q64.pop_front());
        if (acc64) exp_q64.push_back(d);
        if (con8)  void'(exp_q8.pop_front());
        if (acc8)  exp_q8.push_back(d[63:56]);
      end
    end
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    // Reset held with a beat offered: nothing may be accepted or shown.
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_data64 = 64'hDEADBEEF; in_data8 = 8'hEF;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid64), 64'h0);
    check_eq("rst_out_data",  out_data64,       64'h0);
    check_eq("rst_in_ready",  64'(in_ready64),  64'h0);
    check_eq("rst_in_ready8", 64'(in_ready8),   64'h0);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 64'(in_ready64), 64'h1);
    @(negedge clk);

    // Streaming: one beat per cycle, each visible right after its edge.
    for (int i = 1; i <= 4; i++) begin
      drive_cycle(1'b1, 64'(i), 1'b1, 1'b1, 1'b0);
      check_eq("stream_data", out_data64, 64'(i));
      check_eq("stream_in_ready", 64'(in_ready64), 64'h1);
    end
    drive_cycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
    check_eq("stream_drained", 64'(out_valid64), 64'h0);

    // Backpressure: fill to FULL, then drain in order.
    drive_cycle(1'b1, 64'hA, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b1, 64'hB, 1'b0, 1'b1, 1'b0);
    check_eq("bp_full_in_ready", 64'(in_ready64), 64'h0);
    check_eq("bp_full_data",     out_data64,      64'hA);
    check_eq("bp_full_state",    64'(dbg64),      64'(ST_FULL));
    drive_cycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
    check_eq("bp_second_data", out_data64,      64'hB);
    check_eq("bp_in_ready",    64'(in_ready64), 64'h1);
    drive_cycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
    check_eq("bp_empty", 64'(out_valid64), 64'h0);

    // Flush from FULL with a simultaneous offer: everything is lost.
    drive_cycle(1'b1, 64'h11, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b1, 64'h22, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b1, 64'h33, 1'b1, 1'b1, 1'b1);
    check_eq("flush_out_valid", 64'(out_valid64), 64'h0);
    check_eq("flush_out_data",  out_data64,       64'h0);
    check_eq("flush_in_ready",  64'(in_ready64),  64'h1);
    drive_cycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
    check_eq("flush_no_33", 64'(out_valid64), 64'h0);

    // Freeze: rdy low ignores flush and consume; the beat survives.
    drive_cycle(1'b1, 64'h55, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 64'h66, 1'b1, 1'b0, 1'b1);
      check_eq("freeze_out_valid", 64'(out_valid64), 64'h0);
      check_eq("freeze_in_ready",  64'(in_ready64),  64'h0);
    end
    rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check_eq("thaw_out_valid", 64'(out_valid64), 64'h1);
    check_eq("thaw_out_data",  out_data64,       64'h55);
    @(negedge clk);
    drive_cycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a transfer drops the held beat.
    drive_cycle(1'b1, 64'h77, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_eq("midrst_out_valid", 64'(out_valid64), 64'h0);
    check_eq("midrst_out_data",  out_data64,       64'h0);
    check_eq("midrst_in_ready",  64'(in_ready64),  64'h0);
    exp_q64.delete();
    exp_q8.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_release_in_ready", 64'(in_ready64), 64'h1);
    check_eq("midrst_release_valid",    64'(out_valid64), 64'h0);
    @(negedge clk);

    // Random traffic on both widths.
    for (int i = 0; i < 10000; i++) begin
      drive_cycle($urandom_range(0, 99) < 70, {$urandom, $urandom},
                  $urandom_range(0, 99) < 60, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 29) == 0);
    end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
    end
    check_eq("final_empty64", 64'(out_valid64), 64'h0);
    check_eq("final_empty8",  64'(out_valid8),  64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
